cle_pixel_fetch: RTL and testbench

Upstream feeder for the component labeling engine (CLE). Reads the packed binary image, 32x32 pixels at 1 bit/pixel, from the 128x8 synchronous ROM. Emits one pixel per cycle in raster order, with coordinates, over a valid/ready handshake. The CLE labeling core consumes this stream instead of addressing the ROM itself.

---
 rtl/cle_pkg.sv | 17 +
 rtl/cle_byte_fifo.sv | 38 +++
 rtl/cle_pixel_fetch.sv | 134 +++++++++++++
 tb/tb_cle_pixel_fetch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cle_pkg.sv
// Shared constants and fetch FSM encoding for the CLE pixel fetcher.
package cle_pkg;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam int ROM_AW = 7;
  localparam int CNT_W  = 11;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM,
    DONE
  } fetch_state_t;
endpackage

// File: rtl/cle_byte_fifo.sv
// Two-entry byte FIFO holding prefetched ROM bytes ahead of the pixel shifter.
module cle_byte_fifo
  import cle_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic [1:0]        count
);
  logic [BYTE_W-1:0] mem [2];
  logic wr_ptr;
  logic rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/cle_pixel_fetch.sv
// Streams a packed 1bpp image from a synchronous ROM as raster-order pixels.
// Define STAT_EN to add the fg_count foreground-pixel counter output.
module cle_pixel_fetch #(
  parameter int IMG_W  = cle_pkg::IMG_W,
  parameter int IMG_H  = cle_pkg::IMG_H,
  parameter int ROM_AW = cle_pkg::ROM_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [ROM_AW-1:0]        rom_a,
  input  logic [7:0]               rom_q,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix,
  output logic [$clog2(IMG_W)-1:0] pix_x,
  output logic [$clog2(IMG_H)-1:0] pix_y,
  output logic                     pix_last,
  output logic                     busy,
  output logic                     done
`ifdef STAT_EN
  ,
  output logic [cle_pkg::CNT_W-1:0] fg_count
`endif
);
  import cle_pkg::*;

  localparam int PXW = $clog2(IMG_W);
  localparam int PYW = $clog2(IMG_H);

  fetch_state_t state, state_nx;

  logic [7:0]      sh_data;
  logic [2:0]      bit_cnt;
  logic            rd_p1, rd_p2;
  logic [ROM_AW:0] rd_cnt;
  logic [7:0]      fifo_dout;
  logic [1:0]      fifo_cnt;

  logic       active, start_acc, consume, issue, want_load;
  logic       load_fifo, load_bypass, fifo_push, fifo_pop;
  logic [7:0] load_byte;

  cle_byte_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rom_q),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );

  // rd_p1/rd_p2 track a read through the ROM's two-edge pipeline; the FIFO
  // plus both stages may never exceed two bytes, so pushes cannot overflow.
  always_comb begin
    state_nx    = state;
    active      = (state == PREFETCH) || (state == STREAM);
    start_acc   = (state == IDLE) && start;
    consume     = pix_valid && pix_ready;
    issue       = active && !rd_cnt[ROM_AW] &&
                  (({1'b0, fifo_cnt} + {2'b0, rd_p1} + {2'b0, rd_p2}) < 3'd2);
    want_load   = active && (!pix_valid || (consume && bit_cnt == 3'd7));
    load_fifo   = want_load && (fifo_cnt != 2'd0);
    load_bypass = want_load && (fifo_cnt == 2'd0) && rd_p2;
    fifo_push   = rd_p2 && !load_bypass;
    fifo_pop    = load_fifo;
    load_byte   = load_fifo ? fifo_dout : rom_q;

    case (state)
      IDLE:     if (start) state_nx = PREFETCH;
      PREFETCH: if (rd_p2) state_nx = STREAM;
      STREAM:   if (consume && pix_last) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rom_a     <= '0;
      rd_cnt    <= '0;
      rd_p1     <= 1'b0;
      rd_p2     <= 1'b0;
      sh_data   <= '0;
      bit_cnt   <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      state <= state_nx;
      rd_p1 <= issue || start_acc;
      rd_p2 <= rd_p1;

      if (start_acc) begin
        rom_a  <= '0;
        rd_cnt <= (ROM_AW+1)'(1);
        pix_x  <= '0;
        pix_y  <= '0;
      end else if (issue) begin
        rom_a  <= rd_cnt[ROM_AW-1:0];
        rd_cnt <= rd_cnt + (ROM_AW+1)'(1);
      end

      if (load_fifo || load_bypass) begin
        sh_data   <= load_byte;
        bit_cnt   <= '0;
        pix_valid <= 1'b1;
      end else if (consume) begin
        sh_data <= {sh_data[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) pix_valid <= 1'b0;
      end

      if (consume) begin
        pix_x <= pix_x + PXW'(1);
        if (&pix_x) pix_y <= pix_y + PYW'(1);
      end
    end
  end

`ifdef STAT_EN
  always_ff @(posedge clk) begin
    if (reset || start_acc) fg_count <= '0;
    else if (consume && pix) fg_count <= fg_count + CNT_W'(1);
  end
`endif

  assign pix      = sh_data[7];
  assign pix_last = pix_valid && (&pix_x) && (&pix_y);
  assign busy     = active;
  assign done     = (state == DONE);
endmodule

// File: tb/tb_cle_pixel_fetch.sv
// Directed bench for cle_pixel_fetch: ROM model, per-pixel expected stream,
// backpressure hold, ignored start, mid-frame reset and optional STAT_EN count.
module tb_cle_pixel_fetch;
  logic       clk = 1'b0;
  logic       reset, start, pix_ready;
  logic [6:0] rom_a;
  logic [7:0] rom_q;
  logic       pix_valid, pix, pix_last, busy, done;
  logic [4:0] pix_x, pix_y;
`ifdef STAT_EN
  logic [10:0] fg_count;
`endif

  logic [7:0] rom [128];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[rom_a];

  cle_pixel_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rom_a     (rom_a),
    .rom_q     (rom_q),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix       (pix),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done)
`ifdef STAT_EN
    ,
    .fg_count  (fg_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {pix, last, y, x} expected for pixel index i
  function automatic logic [11:0] exp_word(input int i);
    logic [7:0] b;
    logic       p;
    b = rom[i / 8];
    p = b[3'(7 - (i % 8))];
    return {p, (i == 1023), 5'(i / 32), 5'(i % 32)};
  endfunction

  function automatic int exp_fg();
    int n = 0;
    for (int k = 0; k < 128; k++)
      for (int j = 0; j < 8; j++) n += int'(rom[k][j]);
    return n;
  endfunction

  task automatic run_frame(input bit rand_ready, input int restart_at,
                           input int abort_at, input bit chk_timing);
    int c, hs, first_c, done_c, dones, lasts;
    logic [12:0] held, cur;
    bit held_v, aborted;
    hs = 0; first_c = -1; done_c = -1; dones = 0; lasts = 0;
    held = '0; held_v = 0; aborted = 0;
    @(negedge clk);
    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c < 4000) begin
      cur = {pix_valid, pix, pix_last, pix_y, pix_x};
      if (pix_valid && first_c < 0) first_c = c;
      if (held_v) begin
        check("hold", cur, held);
        held_v = 0;
      end
      if (done) begin
        dones++;
        if (done_c < 0) done_c = c;
        check("busy_at_done", busy, 0);
`ifdef STAT_EN
        check("fg_count", fg_count, exp_fg());
`endif
      end
      if (done_c > 0 && c >= done_c + 2) break;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (c == restart_at);
      if (pix_valid) begin
        if (pix_ready) begin
          check("pixel", cur[11:0], exp_word(hs));
          if (pix_last) lasts++;
          hs++;
        end else begin
          held = cur;
          held_v = 1;
        end
      end
      if (abort_at >= 0 && hs == abort_at) begin
        aborted = 1;
        break;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_valid", pix_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_xy", {pix_y, pix_x}, 0);
    end else begin
      check("handshakes", hs, 1024);
      check("done_pulses", dones, 1);
      check("last_count", lasts, 1);
      check("end_valid", pix_valid, 0);
      check("end_busy", busy, 0);
      if (chk_timing) begin
        check("first_valid_cycle", first_c, 3);
        check("done_cycle", done_c, 1027);
      end
    end
    pix_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    pix_ready = 1'b0;
    for (int k = 0; k < 128; k++) rom[k] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rom_a", rom_a, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_pix", pix, 0);
    check("rst_x", pix_x, 0);
    check("rst_y", pix_y, 0);
    check("rst_last", pix_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef STAT_EN
    check("rst_fg", fg_count, 0);
`endif
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", pix_valid, 0);

    // foreground at (0,0), (31,0), (31,31)
    rom[0] = 8'h80; rom[3] = 8'h01; rom[127] = 8'h01;
    run_frame(0, -1, -1, 1);

    for (int k = 0; k < 128; k++) rom[k] = 8'(k * 37 + 11);
    run_frame(1, -1, -1, 0);
    run_frame(0, 400, -1, 1);
    run_frame(0, -1, 500, 0);
    run_frame(0, -1, -1, 1);

`ifdef STAT_EN
    for (int k = 0; k < 128; k++) rom[k] = 8'hFF;
    run_frame(0, -1, -1, 0);
    check("fg_all_ones", fg_count, 1024);
    for (int k = 0; k < 128; k++) rom[k] = 8'h00;
    run_frame(0, -1, -1, 0);
    check("fg_all_zero", fg_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
